// File: rtl/ita_fifo_v3.sv
// rtl/ita_fifo_v3.sv - parameterised FIFO with optional fall-through and pass-through; checks enabled by ITA_FIFO_ASSERT_EN
module ita_fifo_v3 #(
  parameter bit FALL_THROUGH = 1'b0,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  localparam int ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  // DFT bypass has no functional effect on this block
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  if (DEPTH == 0) begin : g_pass_through
    // No storage: the consumer sees the producer directly
    logic unused_pt;
    assign unused_pt = ^{clk_i, rst_ni, flush_i};
    assign data_o    = data_i;
    assign empty_o   = !push_i;
    assign full_o    = !pop_i;
    assign usage_o   = '0;
  end else begin : g_fifo
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  is_empty_cnt;
    logic                  bypass;
    logic                  push_ok;
    logic                  pop_ok;

    assign is_empty_cnt = (count_q == '0);
    assign full_o       = (count_q == FULL_CNT);
    assign empty_o      = is_empty_cnt && !(FALL_THROUGH && push_i);
    // A full power-of-two FIFO wraps usage to 0; full_o tells the cases apart
    assign usage_o      = count_q[ADDR_DEPTH-1:0];
    assign data_o       = (FALL_THROUGH && is_empty_cnt && push_i) ? data_i : mem_q[rd_ptr_q];

    // Decide accepted push/pop and compute next pointers and count
    always_comb begin
      // Fall-through push consumed in the same cycle never touches storage
      bypass   = FALL_THROUGH && is_empty_cnt && push_i && pop_i;
      push_ok  = push_i && !full_o && !bypass;
      pop_ok   = pop_i && !empty_o && !bypass;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (flush_i) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage written only by an accepted push that a flush does not cancel
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else if (push_ok && !flush_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

`ifdef ITA_FIFO_ASSERT_EN
  if (DEPTH < 0) begin : g_depth_check
    $fatal(1, "ita_fifo_v3: DEPTH must not be negative");
  end

  // Flag producer pushing into a full FIFO
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $error("ita_fifo_v3: push while full");

  // Flag consumer popping an empty FIFO
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
    else $error("ita_fifo_v3: pop while empty");
`endif

endmodule

// File: tb/tb_ita_fifo_v3.sv
// tb/tb_ita_fifo_v3.sv - self-checking bench for ita_fifo_v3 against a queue reference model
module tb_ita_fifo_v3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          testmode;
  logic [DW-1:0] din;
  logic          push, pop;
  logic          full, empty;
  logic [AW-1:0] usage;
  logic [DW-1:0] dout;
  logic          ft_push, ft_pop;
  logic          ft_full, ft_empty;
  logic [AW-1:0] ft_usage;
  logic [DW-1:0] ft_dout;

  int checks = 0;
  int errors = 0;
  byte unsigned q[$];

  always #5 clk = ~clk;

  ita_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
    .full_o(full), .empty_o(empty), .usage_o(usage),
    .data_i(din), .push_i(push), .data_o(dout), .pop_i(pop)
  );

  ita_fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
    .full_o(ft_full), .empty_o(ft_empty), .usage_o(ft_usage),
    .data_i(din), .push_i(ft_push), .data_o(ft_dout), .pop_i(ft_pop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".usage"}, 32'(usage), 32'(n % DEPTH));
    if (n > 0) check({tag, ".data"}, 32'(dout), 32'(q[0]));
  endtask

  // One clock of stimulus on the main FIFO; outputs checked just before the edge
  task automatic step(input logic p, input logic o, input logic [DW-1:0] d,
                      input logic f, input string tag);
    bit acc_push, acc_pop;
    @(negedge clk);
    push = p; pop = o; din = d; flush = f;
    #1;
    check_state(tag);
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      acc_push = p && (q.size() < DEPTH);
      acc_pop  = o && (q.size() > 0);
      if (acc_pop)  void'(q.pop_front());
      if (acc_push) q.push_back(d);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; testmode = 1'b0; din = '0;
    push = 1'b0; pop = 1'b0; ft_push = 1'b0; ft_pop = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.usage", 32'(usage), 32'd0);
    check("rst.data",  32'(dout),  32'd0);
    check("rst.ft_empty", 32'(ft_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then drain in order
    step(1, 0, 8'h11, 0, "fill");
    step(1, 0, 8'h22, 0, "fill");
    step(1, 0, 8'h33, 0, "fill");
    step(1, 0, 8'h44, 0, "fill");
    step(0, 0, 8'h00, 0, "full");
    check("full.usage0", 32'(usage), 32'd0);
    check("full.head",   32'(dout),  32'h11);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, "drain");
    step(0, 0, 8'h00, 0, "drained");

    // Push ignored while full; pop ignored while empty
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h11 * (i + 1)), 0, "refill");
    step(1, 0, 8'h55, 0, "push_full");
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, "drain2");
    step(0, 1, 8'h00, 0, "pop_empty");
    step(0, 0, 8'h00, 0, "after_pop_empty");

    // Simultaneous push and pop with two held
    step(1, 0, 8'h01, 0, "two");
    step(1, 0, 8'h02, 0, "two");
    step(1, 1, 8'h66, 0, "pushpop");
    step(0, 0, 8'h00, 0, "pushpop_after");
    check("pushpop.usage", 32'(usage), 32'd2);
    check("pushpop.head",  32'(dout),  32'h02);
    step(0, 1, 8'h00, 0, "clr");
    step(0, 1, 8'h00, 0, "clr");

    // Flush with three held, then a fresh push
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i), 0, "pre_flush");
    step(1, 1, 8'hEE, 1, "flush");
    step(1, 0, 8'h77, 0, "post_flush");
    step(0, 0, 8'h00, 0, "post_flush_push");
    check("flush.head", 32'(dout), 32'h77);
    step(0, 1, 8'h00, 0, "clr");

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hD0 + i), 0, "pre_rst");
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.empty", 32'(empty), 32'd1);
    check("arst.usage", 32'(usage), 32'd0);
    check("arst.data",  32'(dout),  32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 8'h00, 0, "post_rst");

    // Interleaved traffic wraps the pointers
    step(1, 0, 8'h80, 0, "wrap");
    for (int i = 1; i < 6; i++) step(1, 1, 8'(8'h80 + i), 0, "wrap");
    step(0, 1, 8'h00, 0, "wrap");
    step(0, 0, 8'h00, 0, "wrap_end");

    // Fall-through: push with pop on empty passes straight through
    @(negedge clk);
    ft_push = 1'b1; ft_pop = 1'b1; din = 8'hA5;
    #1;
    check("ft.data_same", 32'(ft_dout),  32'hA5);
    check("ft.empty_same", 32'(ft_empty), 32'd0);
    @(negedge clk);
    ft_push = 1'b0; ft_pop = 1'b0;
    #1;
    check("ft.empty_after", 32'(ft_empty), 32'd1);
    check("ft.usage_after", 32'(ft_usage), 32'd0);
    @(negedge clk);
    ft_push = 1'b1; din = 8'h3C;
    #1;
    check("ft.data_push", 32'(ft_dout), 32'h3C);
    @(negedge clk);
    ft_push = 1'b0;
    #1;
    check("ft.usage_one", 32'(ft_usage), 32'd1);
    check("ft.data_held", 32'(ft_dout),  32'h3C);
    check("ft.full",      32'(ft_full),  32'd0);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 19) == 0), "rand");
    end
    step(0, 0, 8'h00, 0, "rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
